// File: rtl/mem_responder.sv
// mem_responder: single-port multi-cycle word memory on the target side of the main-memory bus.
// Optional MEM_RESP_ADDR_CHECK_EN: out-of-range requests raise m_err, suppress writes and read 32'hdead_beef.
module mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] m_a,
    input  logic [31:0] m_d_w,
    input  logic        m_access,
    input  logic        m_write,
    output logic [31:0] m_d_r,
    output logic        m_ready,
    output logic        busy,
    output logic        m_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              oor_q, oor_d;
    logic [31:0]       m_d_r_q, m_d_r_d;
    logic              m_ready_q, m_ready_d;
    logic              busy_q, busy_d;
    logic              m_err_q, m_err_d;
    logic              mem_we;
    logic              req_oor;
    logic              unused_bits;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

`ifdef MEM_RESP_ADDR_CHECK_EN
    assign req_oor     = |m_a[31:ADDR_W+2];
    assign unused_bits = ^m_a[1:0];
`else
    // Upper bits dropped: addresses alias modulo the memory size.
    assign req_oor     = 1'b0;
    assign unused_bits = ^{m_a[31:ADDR_W+2], m_a[1:0]};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        oor_d     = oor_q;
        m_d_r_d   = m_d_r_q;
        m_ready_d = 1'b0;
        m_err_d   = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m_access) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                    idx_d   = m_a[ADDR_W+1:2];
                    wdata_d = m_d_w;
                    write_d = m_write;
                    oor_d   = req_oor;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Commit and read happen on the edge that enters READY.
                    state_d   = S_READY;
                    m_ready_d = 1'b1;
                    m_err_d   = oor_q;
                    if (write_q) begin
                        mem_we = !oor_q;
                    end else begin
                        m_d_r_d = oor_q ? 32'hdead_beef : mem[idx_q];
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            m_d_r_q   <= 32'd0;
            m_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_d_r_q   <= m_d_r_d;
            m_ready_q <= m_ready_d;
            busy_q    <= busy_d;
            m_err_q   <= m_err_d;
        end
    end

    // Latched request fields are only consumed in WAIT, so they need no reset.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        write_q <= write_d;
        oor_q   <= oor_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign m_d_r   = m_d_r_q;
    assign m_ready = m_ready_q;
    assign busy    = busy_q;
    assign m_err   = m_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, corner-case sequences and a
// randomized two-requester run checked against a word-array reference model.
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int AW  = 10;
    localparam int LAT = 3;
`ifdef MEM_RESP_ADDR_CHECK_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_d_w = 32'd0;
    logic        m_access = 1'b0;
    logic        m_write = 1'b0;
    logic [31:0] m_d_r;
    logic        m_ready;
    logic        busy;
    logic        m_err;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .m_a      (m_a),
        .m_d_w    (m_d_w),
        .m_access (m_access),
        .m_write  (m_write),
        .m_d_r    (m_d_r),
        .m_ready  (m_ready),
        .busy     (busy),
        .m_err    (m_err)
    );

    int errors = 0;
    int checks = 0;
    int ready_cnt = 0;
    always @(negedge clk) if (m_ready === 1'b1) ready_cnt <= ready_cnt + 1;

    logic [31:0] mdl [0:(1<<AW)-1];
    logic [31:0] last_rd = 32'd0;
    bit          b2b = 1'b0;

    typedef struct {
        int          gap;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tbl [14];
    logic [31:0] pool [7];

    function automatic bit is_oor(input logic [31:0] a);
        return CK && (a[31:AW+2] != '0);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int k);
        m_access = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                check("idle_ready_low", 32'(m_ready), 32'd0);
                check("idle_busy_low", 32'(busy), 32'd0);
            end
            check("hold_d_r", m_d_r, last_rd);
            check("idle_err_low", 32'(m_err), 32'd0);
        end
        b2b = 1'b0;
    endtask

    // Issues one request and leaves m_access high so a following call is back-to-back.
    task automatic txn(input string nm, input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [31:0] exp_rd, input logic exp_err);
        int n;
        int bc;
        int exp_n;
        exp_n = b2b ? LAT + 2 : LAT + 1;
        m_a = a; m_d_w = d; m_write = w; m_access = 1'b1;
        n = 0; bc = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (busy === 1'b1) bc++;
        end while (m_ready !== 1'b1 && n < 40);
        check({nm, "_lat"}, 32'(n), 32'(exp_n));
        check({nm, "_busy"}, 32'(bc), 32'(LAT + 1));
        check({nm, "_rd"}, m_d_r, exp_rd);
        check({nm, "_err"}, 32'(m_err), 32'(exp_err));
        last_rd = exp_rd;
        b2b = 1'b1;
    endtask

    task automatic mtxn(input string nm, input logic [31:0] a, input logic [31:0] d, input logic w);
        logic [31:0] e;
        logic        oor;
        oor = is_oor(a);
        if (w) begin
            e = last_rd;
            if (!oor) mdl[widx(a)] = d;
        end else begin
            e = oor ? 32'hdead_beef : mdl[widx(a)];
        end
        txn(nm, a, d, w, e, oor);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        int          base;
        logic [31:0] got;
        logic [31:0] a;

        tbl[0]  = '{1, 32'h10,        32'h1234_5678, 1'b1, 32'h0,          1'b0};
        tbl[1]  = '{1, 32'h10,        32'h0,         1'b0, 32'h1234_5678,  1'b0};
        tbl[2]  = '{0, 32'h20,        32'hcafe_f00d, 1'b1, 32'h1234_5678,  1'b0};
        tbl[3]  = '{0, 32'h20,        32'h0,         1'b0, 32'hcafe_f00d,  1'b0};
        tbl[4]  = '{0, 32'h0,         32'ha5a5_0000, 1'b1, 32'hcafe_f00d,  1'b0};
        tbl[5]  = '{0, 32'h8,         32'h0,         1'b1, 32'hcafe_f00d,  1'b0};
        tbl[6]  = '{0, 32'h40,        32'h0bad_cafe, 1'b1, 32'hcafe_f00d,  1'b0};
        tbl[7]  = '{2, 32'h0001_0000, 32'h0,         1'b0, CK ? 32'hdead_beef : 32'ha5a5_0000, CK};
        tbl[8]  = '{0, 32'h0001_0000, 32'h1111_1111, 1'b1, CK ? 32'hdead_beef : 32'ha5a5_0000, CK};
        tbl[9]  = '{0, 32'h0,         32'h0,         1'b0, CK ? 32'ha5a5_0000 : 32'h1111_1111, 1'b0};
        tbl[10] = '{0, 32'h13,        32'h0,         1'b0, 32'h1234_5678,  1'b0};
        tbl[11] = '{0, 32'h22,        32'h0,         1'b0, 32'hcafe_f00d,  1'b0};
        tbl[12] = '{1, 32'hffc,       32'h7777_0001, 1'b1, 32'hcafe_f00d,  1'b0};
        tbl[13] = '{0, 32'hffc,       32'h0,         1'b0, 32'h7777_0001,  1'b0};
        pool = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h40, 32'h80, 32'hffc};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(m_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_d_r", m_d_r, 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        clrn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].gap > 0) idle(tbl[i].gap);
            txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].exp_rd, tbl[i].exp_err);
            if (tbl[i].w && !is_oor(tbl[i].a)) mdl[widx(tbl[i].a)] = tbl[i].d;
        end

        // Inputs change and m_access drops while the read is in flight.
        idle(1);
        m_a = 32'h10; m_write = 1'b0; m_access = 1'b1;
        @(posedge clk); #1;
        check("mid_accept_busy", 32'(busy), 32'd1);
        m_a = 32'h40; m_write = 1'b1; m_d_w = 32'hffff_ffff; m_access = 1'b0;
        pulses = 0; got = 32'd0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (m_ready === 1'b1) begin
                pulses++;
                got = m_d_r;
            end
        end
        check("mid_pulses", 32'(pulses), 32'd1);
        check("mid_data", got, 32'h1234_5678);
        check("mid_busy_end", 32'(busy), 32'd0);
        last_rd = 32'h1234_5678;
        b2b = 1'b0;
        mtxn("mid_no_write", 32'h40, 32'h0, 1'b0);

        // Reset in WAIT aborts the write.
        idle(1);
        base = ready_cnt;
        m_a = 32'h8; m_d_w = 32'h5555_aaaa; m_write = 1'b1; m_access = 1'b1;
        @(posedge clk); #1;
        check("abort_accept_busy", 32'(busy), 32'd1);
        m_access = 1'b0;
        #2 clrn = 1'b0;
        #1;
        check("abort_busy_async", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_ready_low", 32'(m_ready), 32'd0);
        clrn = 1'b1;
        check("abort_d_r_reset", m_d_r, 32'd0);
        last_rd = 32'd0;
        idle(LAT + 2);
        check("abort_no_pulse", 32'(ready_cnt - base), 32'd0);
        b2b = 1'b0;
        mtxn("abort_readback", 32'h8, 32'h0, 1'b0);

        // Two requesters alternating, random addresses/ops/gaps.
        mtxn("pre4", 32'h4, $urandom, 1'b1);
        mtxn("pre80", 32'h80, $urandom, 1'b1);
        idle(1);
        base = ready_cnt;
        for (int i = 0; i < 100; i++) begin
            a = pool[$urandom_range(0, 6)];
            if (i % 2 == 1) a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 255)) << 16);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            mtxn($sformatf("rnd%0d_req%0d", i, i % 2), a, $urandom, 1'($urandom_range(0, 1)));
        end
        idle(2);
        check("rnd_total_pulses", 32'(ready_cnt - base), 32'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Target side of the shared main-memory bus: a single-port, multi-cycle word memory that accepts one request at a time on the `m_a`/`m_d_w`/`m_access`/`m_write` lines and answers with a one-cycle `m_ready` pulse and read data on `m_d_r`. It sits below the dual-core memory arbiter and serves whichever core the arbiter selects. It provides configurable access latency so that cache, TLB and arbitration behaviour can be exercised against realistic slow memory.

## Interface
- `ADDR_W`, 10: word-address bits; the memory holds 2^ADDR_W 32-bit words.
- `LATENCY`, 3: wait cycles between acceptance and `m_ready`; legal range 1..15.
- `clk`  in  1  clock, rising edge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `m_a`  in  32  byte address; word index is `m_a[ADDR_W+1:2]`; `m_a[1:0]` is ignored.
- `m_d_w`  in  32  write data.
- `m_access`  in  1  request valid.
- `m_write`  in  1  1 = write, 0 = read.
- `m_d_r`  out  32  read data; valid while `m_ready` is high.
- `m_ready`  out  1  transaction-complete pulse, exactly one cycle wide.
- `busy`  out  1  high in WAIT and READY.
- `m_err`  out  1  address-error flag, qualified by `m_ready`; see Configuration.

## Operation
- FSM states: IDLE, WAIT, READY. All outputs are registered.
- IDLE, when `m_access`=1 at an edge:
  - latch `m_a`, `m_d_w` and `m_write`;
  - load `cnt <= LATENCY-1`;
  - go to WAIT.
- IDLE, when `m_access`=0: stay in IDLE.
- WAIT, `cnt`≠0: `cnt <= cnt-1`.
- WAIT, `cnt`=0: go to READY at that edge, with these effects on the same edge:
  - `m_ready <= 1`;
  - read: `m_d_r <= mem[idx]`;
  - write: `mem[idx] <= wdata`, and `m_d_r` is unchanged.
- READY: at the next edge, `m_ready <= 0` and the FSM goes to IDLE unconditionally. A request cannot be accepted in READY.
- Bus inputs are ignored outside IDLE. The latched request always completes, even if `m_access` drops or the arbiter reselects mid-transaction.
- `m_d_r` holds its last read value between transactions.
- Memory array contents are not reset. Only the FSM, `cnt` and the output registers are reset.

## Timing
- Reset values: state IDLE, `cnt`=0, `m_ready`=0, `m_d_r`=0, `busy`=0, `m_err`=0.
- Acceptance edge E0: `m_ready` is high from edge E0+LATENCY to edge E0+LATENCY+1. The requester samples it at E0+LATENCY+1.
- The earliest next acceptance is edge E0+LATENCY+2, because IDLE always lasts at least one cycle. Back-to-back throughput is one transfer per LATENCY+2 cycles.
- A requester that holds `m_access` high continuously is served repeatedly. It must present its new address by the cycle after `m_ready`.
- Write commit happens on the edge that enters READY. A read of the same word accepted afterwards returns the new data.
- `clrn` low in WAIT aborts the transaction: no write is committed and no `m_ready` is produced.
- `clrn` low in READY: the write has already been committed; `m_ready` is cleared immediately (asynchronously).

## Configuration
- `MEM_RESP_ADDR_CHECK_EN` defined:
  - A request whose `m_a[31:ADDR_W+2]` is nonzero is out of range.
  - It still follows the full latency and `m_ready` timing.
  - A write is suppressed.
  - A read returns `m_d_r = 32'hdead_beef`.
  - `m_err` is 1 while `m_ready` is 1; otherwise `m_err` is 0.
- `MEM_RESP_ADDR_CHECK_EN` undefined:
  - Upper address bits are ignored, so addresses alias modulo 2^ADDR_W words.
  - `m_err` is tied to 0.

## Test plan
- Reset, then read with LATENCY=3: after pre-loading `mem[4]`=32'h1234_5678 via a write, a read of `m_a`=32'h10 accepted at E0 → `m_ready` high exactly during cycle E0+3..E0+4, with `m_d_r`=32'h1234_5678; `busy` high for 4 cycles.
- Write then read, LATENCY=1: write 32'hcafe_f00d to 32'h20, then read 32'h20 with `m_access` held high throughout → second acceptance exactly 3 cycles after the first, read returns 32'hcafe_f00d, `m_d_r` unchanged during the write's `m_ready`.
- Mid-transaction input change: during WAIT change `m_a` to 32'h40 and drop `m_access` → the originally latched address is read, `m_ready` still pulses once, and no second transaction is accepted.
- Reset during WAIT of a write of 32'h5555_aaaa to 32'h8 (old value 0) → `m_ready` never asserts, FSM returns to IDLE, and a later read of 32'h8 returns 0.
- Out-of-range access, with `m_a`=32'h0001_0000 and ADDR_W=10:
  - with `MEM_RESP_ADDR_CHECK_EN` defined, a read returns 32'hdead_beef with `m_err`=1, and a write leaves `mem[0]` unchanged;
  - with it undefined, the access aliases to word 0 and `m_err`=0.
- Arbiter integration: two requesters alternating through the dual-core arbiter with LATENCY=2 → each gets exactly one `m_ready` per request, with no lost or duplicated transactions over 100 random requests compared against a scoreboard model.
